pc_unit: RTL and testbench

- Parametrised program-counter unit for the pipelined MIPS core, replacing the purely combinational next-PC selection.
- Owns the PC register and computes all redirect targets internally (branch, j/jal, jr, exception vector, eret) under a fixed priority.
- Extends branch evaluation from beq-only to the full MIPS compare set.
- Supports fetch stall, with a pending-redirect buffer so that a redirect arriving during a stall is not lost.

---
 rtl/pc_unit.sv | 140 ++++++++++++++
 tb/tb_pc_unit.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Purpose : program-counter unit; owns the PC register and picks the next PC from
//           exception, eret, branch, jr, j/jal or sequential targets.
// Latency : one cycle from inputs to pc; no combinational path from inputs to pc,
//           redirect or pending.
// Backpressure: stall holds pc. The first lower-priority redirect seen during a stall
//           is buffered and applied when the stall releases. exc/eret ignore stall.
// Ports   : clk/reset (sync, active-high); stall; br_en/br_cond/rs_val/rt_val/imm16
//           branch inputs; npc_sel/j_index jump inputs; exc/eret/epc exception
//           inputs; pc/pc4/redirect/pending/pc_misalign outputs.
module pc_unit #(
    parameter int          WIDTH    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC  = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             br_en,
    input  logic [2:0]       br_cond,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    input  logic [15:0]      imm16,
    input  logic [1:0]       npc_sel,
    input  logic [25:0]      j_index,
    input  logic             exc,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc4,
    output logic             redirect,
    output logic             pending,
    output logic             pc_misalign
);

    localparam logic [WIDTH-1:0] RESET_PC_W = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] EXC_VEC_W  = WIDTH'(EXC_VEC);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] buf_q, buf_d;
    logic             pend_q, pend_d;
    logic             redir_q, redir_d;

    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic             rs_neg, rs_zero, cond_ok, taken;
    logic             low_redir;
    logic [WIDTH-1:0] low_tgt;

    assign pc4 = pc_q + WIDTH'(4);

    // Sign-extended word offset, shifted to a byte offset; the add wraps freely.
    assign br_off = {{(WIDTH-18){imm16[15]}}, imm16, 2'b00};
    assign br_tgt = pc4 + br_off;
    assign j_tgt  = {pc4[WIDTH-1:28], j_index, 2'b00};

    // Signed compares against zero reduce to the sign bit and a zero test.
    assign rs_neg  = rs_val[WIDTH-1];
    assign rs_zero = (rs_val == '0);

    always_comb begin
        cond_ok = 1'b0;
        case (br_cond)
            3'b000:  cond_ok = (rs_val == rt_val);
            3'b001:  cond_ok = (rs_val != rt_val);
            3'b010:  cond_ok = rs_neg | rs_zero;
            3'b011:  cond_ok = ~rs_neg & ~rs_zero;
            3'b100:  cond_ok = rs_neg;
            3'b101:  cond_ok = ~rs_neg;
            default: cond_ok = 1'b0;
        endcase
    end

    assign taken = br_en & cond_ok;

    // Redirects below exc/eret: taken branch beats npc_sel; an untaken branch
    // falls through to the jump decode. npc_sel 11 behaves as sequential.
    always_comb begin
        low_redir = 1'b0;
        low_tgt   = pc4;
        if (taken) begin
            low_redir = 1'b1;
            low_tgt   = br_tgt;
        end else if (npc_sel == 2'b01) begin
            low_redir = 1'b1;
            low_tgt   = rs_val;
        end else if (npc_sel == 2'b10) begin
            low_redir = 1'b1;
            low_tgt   = j_tgt;
        end
    end

    always_comb begin
        pc_d    = pc_q;
        buf_d   = buf_q;
        pend_d  = pend_q;
        redir_d = 1'b0;
        if (exc || eret) begin
            pc_d    = exc ? EXC_VEC_W : epc;
            pend_d  = 1'b0;
            redir_d = 1'b1;
        end else if (stall) begin
            // Only the first redirect of a stall window is kept.
            if (!pend_q && low_redir) begin
                buf_d  = low_tgt;
                pend_d = 1'b1;
            end
        end else if (pend_q) begin
            // The buffered redirect is older than this cycle's inputs, so it wins.
            pc_d    = buf_q;
            pend_d  = 1'b0;
            redir_d = 1'b1;
        end else if (low_redir) begin
            pc_d    = low_tgt;
            redir_d = 1'b1;
        end else begin
            pc_d = pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_PC_W;
            buf_q   <= '0;
            pend_q  <= 1'b0;
            redir_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            buf_q   <= buf_d;
            pend_q  <= pend_d;
            redir_q <= redir_d;
        end
    end

    assign pc          = pc_q;
    assign redirect    = redir_q;
    assign pending     = pend_q;
    assign pc_misalign = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_unit.sv
// Purpose : directed bench for pc_unit with hand-computed expected values.
// Latency : inputs are driven 1ns after a rising edge and outputs are checked
//           1ns after the next rising edge.
// Backpressure: exercises stall, the pending-redirect buffer and reset during a stall.
module tb_pc_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, stall, br_en, exc, eret;
    logic [2:0]   br_cond;
    logic [W-1:0] rs_val, rt_val, epc;
    logic [15:0]  imm16;
    logic [1:0]   npc_sel;
    logic [25:0]  j_index;
    logic [W-1:0] pc, pc4;
    logic         redirect, pending, pc_misalign;

    int errors = 0;
    int checks = 0;

    pc_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .stall(stall), .br_en(br_en), .br_cond(br_cond),
        .rs_val(rs_val), .rt_val(rt_val), .imm16(imm16), .npc_sel(npc_sel),
        .j_index(j_index), .exc(exc), .eret(eret), .epc(epc),
        .pc(pc), .pc4(pc4), .redirect(redirect), .pending(pending),
        .pc_misalign(pc_misalign)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Check pc, redirect and pending together.
    task automatic chk3(input string tag, input logic [W-1:0] epc_v, input logic er, input logic ep);
        chk({tag, ".pc"}, pc, epc_v);
        chk({tag, ".redirect"}, W'(redirect), W'(er));
        chk({tag, ".pending"}, W'(pending), W'(ep));
    endtask

    task automatic idle();
        stall = 0; br_en = 0; br_cond = 3'b000; exc = 0; eret = 0;
        rs_val = '0; rt_val = '0; imm16 = '0; npc_sel = 2'b00; j_index = '0; epc = '0;
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        chk3("reset", 32'h3000, 0, 0);
        chk("reset.pc4", pc4, 32'h3004);
        chk("reset.misalign", W'(pc_misalign), 0);
        reset = 0;

        step(); chk3("seq1", 32'h3004, 0, 0);
        step(); chk3("seq2", 32'h3008, 0, 0);
        step(); chk3("seq3", 32'h300C, 0, 0);
        step(); chk3("seq4", 32'h3010, 0, 0);

        // beq taken backwards: 0x3014 - 16
        br_en = 1; br_cond = 3'b000; rs_val = 5; rt_val = 5; imm16 = 16'hFFFC;
        step(); chk3("beq", 32'h3004, 1, 0);
        idle();
        step(); chk3("beq.after", 32'h3008, 0, 0);
        step(); step(); chk("at3010", pc, 32'h3010);
        br_en = 1; br_cond = 3'b001; rs_val = 5; rt_val = 5; imm16 = 16'hFFFC;
        step(); chk3("bne.untaken", 32'h3014, 0, 0);
        idle();

        // bltz taken: 0x3004 + 12
        reset = 1; step(); reset = 0;
        br_en = 1; br_cond = 3'b100; rs_val = 32'hFFFF_FFFF; imm16 = 16'd3;
        step(); chk3("bltz", 32'h3010, 1, 0);
        idle();

        reset = 1; step(); reset = 0;
        br_en = 1; br_cond = 3'b011; rs_val = 0; imm16 = 16'd3;
        step(); chk3("bgtz.untaken", 32'h3004, 0, 0);

        // taken branch beats simultaneous jr
        br_en = 1; br_cond = 3'b101; rs_val = 32'h0000_0100; imm16 = 16'd1; npc_sel = 2'b01;
        step(); chk3("bgez.over.jr", 32'h300C, 1, 0);
        idle();

        // stall with j then jr; j kept, jr ignored
        stall = 1; npc_sel = 2'b10; j_index = 26'h0000_100;
        step(); chk3("stall.j", 32'h300C, 0, 1);
        npc_sel = 2'b01; rs_val = 32'h3100;
        step(); chk3("stall.jr", 32'h300C, 0, 1);
        npc_sel = 2'b00;
        step(); chk3("stall.3", 32'h300C, 0, 1);
        stall = 0; npc_sel = 2'b01; rs_val = 32'h3100;
        step(); chk3("release", 32'h0000_0400, 1, 0);
        idle();
        step(); chk3("release.after", 32'h0000_0404, 0, 0);

        // exc while stalled with pending, then eret while still stalled
        stall = 1; npc_sel = 2'b10; j_index = 26'h0000_200;
        step(); chk3("stall2.j", 32'h0404, 0, 1);
        exc = 1;
        step(); chk3("exc", 32'h4180, 1, 0);
        exc = 0; eret = 1; epc = 32'h3008;
        step(); chk3("eret", 32'h3008, 1, 0);
        idle();
        step(); chk3("eret.after", 32'h300C, 0, 0);

        // exc beats eret
        exc = 1; eret = 1; epc = 32'h5000;
        step(); chk3("exc.over.eret", 32'h4180, 1, 0);
        idle();

        // npc_sel 11 is sequential
        npc_sel = 2'b11; rs_val = 32'h9000;
        step(); chk3("sel11", 32'h4184, 0, 0);
        idle();

        // jr misaligned, never corrected
        npc_sel = 2'b01; rs_val = 32'h3002;
        step(); chk3("jr.mis", 32'h3002, 1, 0);
        chk("jr.mis.flag", W'(pc_misalign), 1);
        idle();
        step(); chk("mis.seq", pc, 32'h3006);
        chk("mis.seq.flag", W'(pc_misalign), 1);

        // wrap-around of pc4 and branch target
        eret = 1; epc = 32'hFFFF_FFFC;
        step(); chk("wrap.pc", pc, 32'hFFFF_FFFC);
        chk("wrap.pc4", pc4, 32'h0000_0000);
        idle();
        br_en = 1; br_cond = 3'b000; rs_val = 1; rt_val = 1; imm16 = 16'd1;
        step(); chk3("wrap.br", 32'h0000_0004, 1, 0);
        idle();

        // reset mid-stall with pending
        stall = 1; npc_sel = 2'b10; j_index = 26'h0000_300;
        step(); chk3("stall3.j", 32'h0004, 0, 1);
        reset = 1;
        step(); chk3("reset.stall", 32'h3000, 0, 0);
        reset = 0; idle();
        step(); chk3("reset.after", 32'h3004, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
